// File: rtl/uart_bus_master.sv
// Command-to-bus bridge for the UART register file.
// Runs a four-phase stb/clk/ack handshake per access, with a wait-state timeout.
module uart_bus_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_error,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data_out,
    input  logic [7:0] wb_data_in,
    output logic       wb_we,
    output logic       wb_clk,
    output logic       wb_stb,
    input  logic       wb_ack
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [7:0] rd_buf, rd_buf_d;
    logic       stb_d, clk_d, we_d;
    logic [1:0] addr_d;
    logic [7:0] dout_d;
    logic       rsp_valid_d, rsp_error_d;
    logic [7:0] rsp_data_d;
    logic       hit;

    assign cmd_ready = (state == IDLE);

    // Abort on the edge where the wait counter would reach TIMEOUT.
    assign hit = ((cnt + 8'd1) == TO);

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rd_buf_d    = rd_buf;
        stb_d       = wb_stb;
        clk_d       = wb_clk;
        we_d        = wb_we;
        addr_d      = wb_addr;
        dout_d      = wb_data_out;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_data_d  = rsp_data;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = REQ;
                    cnt_d   = 8'd0;
                    addr_d  = cmd_addr;
                    dout_d  = cmd_data;
                    we_d    = ~cmd_write;
                    stb_d   = 1'b1;
                    clk_d   = 1'b1;
                end
            end
            REQ: begin
                if (hit) begin
                    state_d     = IDLE;
                    cnt_d       = 8'd0;
                    stb_d       = 1'b0;
                    clk_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                end else if (wb_ack) begin
                    state_d = REL;
                    cnt_d   = 8'd0;
                    clk_d   = 1'b0;
                    if (wb_we) rd_buf_d = wb_data_in;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            REL: begin
                if (hit) begin
                    state_d     = IDLE;
                    cnt_d       = 8'd0;
                    stb_d       = 1'b0;
                    clk_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                end else if (!wb_ack) begin
                    state_d     = IDLE;
                    cnt_d       = 8'd0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (wb_we) rsp_data_d = rd_buf;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                stb_d   = 1'b0;
                clk_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            rd_buf      <= 8'd0;
            wb_stb      <= 1'b0;
            wb_clk      <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= 2'd0;
            wb_data_out <= 8'd0;
            rsp_valid   <= 1'b0;
            rsp_error   <= 1'b0;
            rsp_data    <= 8'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            rd_buf      <= rd_buf_d;
            wb_stb      <= stb_d;
            wb_clk      <= clk_d;
            wb_we       <= we_d;
            wb_addr     <= addr_d;
            wb_data_out <= dout_d;
            rsp_valid   <= rsp_valid_d;
            rsp_error   <= rsp_error_d;
            rsp_data    <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a small UART slave model
// and a response scoreboard.
module tb_uart_bus_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_error;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_out;
    logic [7:0] wb_data_in;
    logic       wb_we;
    logic       wb_clk;
    logic       wb_stb;
    logic       wb_ack;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_error  (rsp_error),
        .wb_addr    (wb_addr),
        .wb_data_out(wb_data_out),
        .wb_data_in (wb_data_in),
        .wb_we      (wb_we),
        .wb_clk     (wb_clk),
        .wb_stb     (wb_stb),
        .wb_ack     (wb_ack)
    );

    // Slave model: 0 = normal UART, 1 = never acks, 2 = ack sticks high
    int         mode = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] div_reg = 8'h00;
    logic [7:0] tx_q[$];

    assign wb_data_in = rx_byte;

    always @(posedge clk) begin
        if (reset) begin
            wb_ack <= 1'b0;
        end else begin
            case (mode)
                1:       wb_ack <= 1'b0;
                2:       wb_ack <= wb_ack | (wb_stb & wb_clk);
                default: wb_ack <= wb_stb & wb_clk;
            endcase
            if (mode == 0 && wb_stb && wb_clk && !wb_ack && !wb_we) begin
                if (wb_addr == 2'd0) tx_q.push_back(wb_data_out);
                else if (wb_addr == 2'd2) div_reg <= wb_data_out;
            end
        end
    end

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one command at a negedge; returns at the negedge of cycle 1.
    task automatic do_cmd(input logic wr, input logic [1:0] a,
                          input logic [7:0] d);
        check("cmd_ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called in cycle 1; waits for rsp_valid and scores it.
    task automatic wait_rsp(input string tag, output int stb_cyc);
        int   lat;
        exp_t e;
        lat     = 1;
        stb_cyc = 0;
        while (!rsp_valid && lat < 40) begin
            if (wb_stb) stb_cyc++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_rsp_seen"}, rsp_valid, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_lat"}, lat, e.lat);
            check({tag, "_err"}, rsp_error, e.err);
            check({tag, "_data"}, rsp_data, e.data);
        end else begin
            check({tag, "_sb_empty"}, 0, 1);
        end
    endtask

    initial begin
        int         sc;
        int         pulses;
        int         cyc1;
        int         cyc2;
        logic [7:0] last_rd;
        exp_t       e;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 2'd0;
        cmd_data  = 8'd0;
        last_rd   = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outs",
              {wb_stb, wb_clk, wb_we, wb_addr, wb_data_out,
               rsp_valid, rsp_error, rsp_data}, 0);
        check("reset_ready", cmd_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Write 0x41 to TX
        sb.push_back('{1'b0, last_rd, 5});
        do_cmd(1'b1, 2'd0, 8'h41);
        check("wr_bus", {wb_stb, wb_clk, wb_we, wb_addr, wb_data_out},
              {1'b1, 1'b1, 1'b0, 2'd0, 8'h41});
        check("wr_busy", cmd_ready, 0);
        wait_rsp("wr41", sc);
        check("wr_stb_cycles", sc, 4);
        check("tx_size", tx_q.size(), 1);
        if (tx_q.size() > 0) check("tx_byte", tx_q.pop_front(), 8'h41);
        @(negedge clk);
        check("wr_pulse_once", rsp_valid, 0);

        // Read 0x5A from RX
        rx_byte = 8'h5A;
        sb.push_back('{1'b0, 8'h5A, 5});
        do_cmd(1'b0, 2'd1, 8'h00);
        check("rd_bus", {wb_stb, wb_we, wb_addr}, {1'b1, 1'b1, 2'd1});
        wait_rsp("rd5a", sc);
        last_rd = 8'h5A;
        @(negedge clk);

        // Slave never acks: REQ timeout
        mode    = 1;
        rx_byte = 8'hC3;
        sb.push_back('{1'b1, last_rd, 5});
        do_cmd(1'b0, 2'd1, 8'h00);
        wait_rsp("to_req", sc);
        check("to_req_stb_cycles", sc, 4);
        check("to_req_bus", {wb_stb, wb_clk}, 0);
        @(negedge clk);
        mode = 0;
        @(negedge clk);

        // Ack sticks high: REL timeout
        mode = 2;
        sb.push_back('{1'b1, last_rd, 7});
        do_cmd(1'b0, 2'd1, 8'h00);
        wait_rsp("to_rel", sc);
        check("to_rel_bus", {wb_stb, wb_clk}, 0);
        @(negedge clk);
        check("idle_ack_high", wb_ack, 1);
        check("idle_ignores_ack", {cmd_ready, wb_stb, rsp_valid}, 3'b100);
        mode = 0;
        @(negedge clk);

        // Back-to-back writes: divider 78 then TX 0x55
        sb.push_back('{1'b0, last_rd, 5});
        sb.push_back('{1'b0, last_rd, 5});
        check("b2b_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 2'd2;
        cmd_data  = 8'd78;
        @(negedge clk);
        check("b2b_busy", cmd_ready, 0);
        cmd_addr = 2'd0;
        cmd_data = 8'h55;
        pulses   = 0;
        cyc1     = 0;
        cyc2     = 0;
        for (int c = 1; c <= 20; c++) begin
            if (pulses >= 1) cmd_valid = 1'b0;
            if (rsp_valid) begin
                pulses++;
                if (pulses == 1) begin
                    cyc1 = c;
                    check("b2b_ready_in_rsp", cmd_ready, 1);
                end else begin
                    cyc2 = c;
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("b2b_err", rsp_error, e.err);
                    check("b2b_data", rsp_data, e.data);
                end
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("b2b_pulses", pulses, 2);
        check("b2b_first_lat", cyc1, 5);
        check("b2b_gap", cyc2 - cyc1, 5);
        check("b2b_div", div_reg, 8'd78);
        check("b2b_tx_size", tx_q.size(), 1);
        if (tx_q.size() > 0) check("b2b_tx_byte", tx_q.pop_front(), 8'h55);

        // Reset while in REL
        rx_byte = 8'h77;
        do_cmd(1'b0, 2'd1, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("in_rel", {wb_stb, wb_clk}, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        check("rst_rel_outs",
              {wb_stb, wb_clk, wb_we, wb_addr, wb_data_out,
               rsp_valid, rsp_error, rsp_data}, 0);
        check("rst_rel_ready", cmd_ready, 1);
        reset  = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("rst_no_rsp", pulses, 0);
        sb.push_back('{1'b0, 8'h77, 5});
        do_cmd(1'b0, 2'd1, 8'h00);
        wait_rsp("rd_after_rst", sc);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
